// File: rtl/uart_v2.sv
// ============================================================================
// Module   : uart_v2 (with helper uart_v2_fifo)
// Brief    : Register-mapped UART, TX/RX FIFOs, 16x oversampling, parity,
//            1/2 stop bits, sticky error flags, level irq, loopback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_v2_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_rptr;
   logic [c_AW:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (c_AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_data    = r_mem[r_rptr];
   // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted then
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module uart_v2 #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int RESET_DIV  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_addr,
   input  logic [7:0] i_wdata,
   input  logic       i_wen,
   input  logic       i_ren,
   output logic [7:0] o_rdata,
   input  logic       i_rx,
   output logic       o_tx,
   output logic       o_irq
);
   typedef enum logic [2:0] {
      TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PAR = 3'd3, TX_STOP = 3'd4
   } tx_state_t;
   typedef enum logic [2:0] {
      RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PAR = 3'd3, RX_STOP = 3'd4
   } rx_state_t;

   logic [7:0]        r_con, r_div, r_div_act, r_tick_cnt, r_rdata;
   logic              r_ovr, r_perr, r_ferr, r_irq, r_tx;
   tx_state_t         r_tx_state, w_tx_nxt;
   logic [3:0]        r_tx_cnt, w_tx_cnt_nxt;
   logic [2:0]        r_tx_bit, w_tx_bit_nxt;
   logic [DATA_W-1:0] r_tx_data;
   logic              w_tx_pop, w_tx_bend, w_tx_bitval, w_tx_busy;
   rx_state_t         r_rx_state, w_rx_nxt;
   logic [3:0]        r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]        r_rx_bit, w_rx_bit_nxt;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_s1, r_rx_s2, r_rx_prev;
   logic              w_rx_in, w_rx_mid, w_rx_shift, w_rx_done, w_perr_set, w_ferr_set;
   logic              w_rx_push, w_ovr_set, w_rxf_pop;
   logic              w_tick, w_wr_con, w_wr_data, w_wr_stat, w_wr_div, w_rd_data;
   logic              w_tx_en, w_rx_en, w_par_en, w_par_odd, w_stop2, w_rxie, w_txie, w_loop;
   logic [DATA_W-1:0] w_txf_data, w_rxf_data;
   logic              w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty;
   logic [7:0]        w_stat, w_rd_mux;

   assign {w_tx_en, w_rx_en, w_par_en, w_par_odd, w_stop2, w_rxie, w_txie, w_loop} = r_con;
   assign w_wr_con  = i_wen && (i_addr == 2'd0);
   assign w_wr_data = i_wen && (i_addr == 2'd1);
   assign w_wr_stat = i_wen && (i_addr == 2'd2);
   assign w_wr_div  = i_wen && (i_addr == 2'd3);
   assign w_rd_data = i_ren && (i_addr == 2'd1);

   // Divisor changes are staged into r_div_act only at a wrap, so no short/long tick occurs
   assign w_tick = (r_tick_cnt == r_div_act);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= 8'd0;
         r_div_act  <= 8'(RESET_DIV);
      end else if (w_tick) begin
         r_tick_cnt <= 8'd0;
         r_div_act  <= r_div;
      end else begin
         r_tick_cnt <= r_tick_cnt + 8'd1;
      end
   end

   uart_v2_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_txf (
      .clk(clk), .rst(rst), .i_push(w_wr_data), .i_data(i_wdata[DATA_W-1:0]),
      .i_pop(w_tx_pop), .o_data(w_txf_data), .o_full(w_txf_full), .o_empty(w_txf_empty)
   );
   uart_v2_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rxf (
      .clk(clk), .rst(rst), .i_push(w_rx_push), .i_data(r_rx_data),
      .i_pop(w_rxf_pop), .o_data(w_rxf_data), .o_full(w_rxf_full), .o_empty(w_rxf_empty)
   );

   assign w_tx_busy = (r_tx_state != TX_IDLE);
   assign w_tx_bend = w_tick && (r_tx_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= 4'd0;
         r_tx_bit   <= 3'd0;
         r_tx_data  <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx_state <= w_tx_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx       <= w_tx_bitval;
         if (w_tx_pop) r_tx_data <= w_txf_data;
      end
   end

   always_comb begin
      w_tx_nxt     = r_tx_state;
      w_tx_cnt_nxt = r_tx_cnt;
      w_tx_bit_nxt = r_tx_bit;
      w_tx_pop     = 1'b0;
      if (w_tx_busy && w_tick)
         w_tx_cnt_nxt = r_tx_cnt + 4'd1;
      case (r_tx_state)
         TX_IDLE: begin
            if (w_tick && w_tx_en && !w_txf_empty) begin
               w_tx_nxt     = TX_START;
               w_tx_pop     = 1'b1;
               w_tx_cnt_nxt = 4'd0;
               w_tx_bit_nxt = 3'd0;
            end
         end
         TX_START: if (w_tx_bend) w_tx_nxt = TX_DATA;
         TX_DATA: begin
            if (w_tx_bend) begin
               if (r_tx_bit == 3'(DATA_W-1)) begin
                  w_tx_nxt     = w_par_en ? TX_PAR : TX_STOP;
                  w_tx_bit_nxt = 3'd0;
               end else begin
                  w_tx_bit_nxt = r_tx_bit + 3'd1;
               end
            end
         end
         TX_PAR: if (w_tx_bend) w_tx_nxt = TX_STOP;
         TX_STOP: begin
            if (w_tx_bend) begin
               if (w_stop2 && (r_tx_bit == 3'd0)) w_tx_bit_nxt = 3'd1;
               else                               w_tx_nxt     = TX_IDLE;
            end
         end
         default: w_tx_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      w_tx_bitval = 1'b1;
      case (r_tx_state)
         TX_START: w_tx_bitval = 1'b0;
         TX_DATA:  w_tx_bitval = r_tx_data[r_tx_bit];
         TX_PAR:   w_tx_bitval = ^r_tx_data ^ w_par_odd;
         default:  w_tx_bitval = 1'b1;
      endcase
   end

   assign w_rx_in  = w_loop ? r_tx : r_rx_s2;
   assign w_rx_mid = w_tick && (r_rx_cnt == ((r_rx_state == RX_START) ? 4'd7 : 4'd15));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= 4'd0;
         r_rx_bit   <= 3'd0;
         r_rx_data  <= '0;
      end else begin
         r_rx_s1    <= i_rx;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= w_rx_in;
         r_rx_state <= w_rx_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         if (w_rx_shift) r_rx_data <= {w_rx_in, r_rx_data[DATA_W-1:1]};
      end
   end

   always_comb begin
      w_rx_nxt     = r_rx_state;
      w_rx_cnt_nxt = r_rx_cnt;
      w_rx_bit_nxt = r_rx_bit;
      w_rx_shift   = 1'b0;
      w_rx_done    = 1'b0;
      w_perr_set   = 1'b0;
      w_ferr_set   = 1'b0;
      if ((r_rx_state != RX_IDLE) && w_tick)
         w_rx_cnt_nxt = r_rx_cnt + 4'd1;
      if (w_rx_mid)
         w_rx_cnt_nxt = 4'd0;
      case (r_rx_state)
         RX_IDLE: begin
            if (w_rx_en && r_rx_prev && !w_rx_in) begin
               w_rx_nxt     = RX_START;
               w_rx_cnt_nxt = 4'd0;
            end
         end
         RX_START: begin
            if (w_rx_mid) begin
               w_rx_nxt     = w_rx_in ? RX_IDLE : RX_DATA;
               w_rx_bit_nxt = 3'd0;
            end
         end
         RX_DATA: begin
            if (w_rx_mid) begin
               w_rx_shift = 1'b1;
               if (r_rx_bit == 3'(DATA_W-1)) w_rx_nxt     = w_par_en ? RX_PAR : RX_STOP;
               else                          w_rx_bit_nxt = r_rx_bit + 3'd1;
            end
         end
         RX_PAR: begin
            if (w_rx_mid) begin
               w_perr_set = (w_rx_in != (^r_rx_data ^ w_par_odd));
               w_rx_nxt   = RX_STOP;
            end
         end
         RX_STOP: begin
            // Only the first stop bit is checked; the line is idle-high after it anyway
            if (w_rx_mid) begin
               w_ferr_set = !w_rx_in;
               w_rx_done  = 1'b1;
               w_rx_nxt   = RX_IDLE;
            end
         end
         default: w_rx_nxt = RX_IDLE;
      endcase
      if (!w_rx_en) begin
         w_rx_nxt   = RX_IDLE;
         w_rx_shift = 1'b0;
         w_rx_done  = 1'b0;
         w_perr_set = 1'b0;
         w_ferr_set = 1'b0;
      end
   end

   assign w_rxf_pop = w_rd_data;
   assign w_rx_push = w_rx_done && (!w_rxf_full || (w_rxf_pop && !w_rxf_empty));
   assign w_ovr_set = w_rx_done && !w_rx_push;

   assign w_stat = {w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty,
                    r_ovr, r_perr, r_ferr, w_tx_busy};

   always_comb begin
      w_rd_mux = 8'h00;
      case (i_addr)
         2'd0:    w_rd_mux = r_con;
         2'd1:    w_rd_mux = w_rxf_empty ? 8'h00 : 8'(w_rxf_data);
         2'd2:    w_rd_mux = w_stat;
         default: w_rd_mux = r_div;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_con   <= 8'h00;
         r_div   <= 8'(RESET_DIV);
         r_ovr   <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_rdata <= 8'h00;
         r_irq   <= 1'b0;
      end else begin
         if (w_wr_con) r_con <= i_wdata;
         if (w_wr_div) r_div <= i_wdata;
         // Set has priority over a same-cycle write-one-to-clear
         r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_stat & i_wdata[3]));
         r_perr <= w_perr_set | (r_perr & ~(w_wr_stat & i_wdata[2]));
         r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_stat & i_wdata[1]));
         if (i_ren) r_rdata <= w_rd_mux;
         r_irq <= (w_rxie & ~w_rxf_empty) | (w_txie & w_txf_empty & ~w_tx_busy);
      end
   end

   assign o_rdata = r_rdata;
   assign o_tx    = r_tx;
   assign o_irq   = r_irq;
endmodule

`default_nettype wire

// File: tb/tb_uart_v2.sv
// ============================================================================
// Module   : tb_uart_v2
// Brief    : Directed, table-driven self-checking bench for uart_v2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_v2;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] addr = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic       wen = 1'b0;
   logic       ren = 1'b0;
   logic [7:0] rdata;
   logic       rx = 1'b1;
   logic       tx;
   logic       irq;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   uart_v2 dut (
      .clk(clk), .rst(rst), .i_addr(addr), .i_wdata(wdata), .i_wen(wen), .i_ren(ren),
      .o_rdata(rdata), .i_rx(rx), .o_tx(tx), .o_irq(irq)
   );

   typedef struct {
      logic       wr;
      logic [1:0] a;
      logic [7:0] d;
      logic [7:0] exp;
      string      name;
   } vec_t;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk); addr = a; wdata = d; wen = 1'b1;
      @(negedge clk); wen = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] v);
      @(negedge clk); addr = a; ren = 1'b1;
      @(negedge clk); ren = 1'b0; v = rdata;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
      logic [7:0] v;
      rd(a, v);
      chk(name, v, exp);
   endtask

   task automatic wait_tx_low(output int w);
      w = 0;
      while (tx !== 1'b0 && w < 3000) begin @(negedge clk); w++; end
      if (w >= 3000) begin
         n_chk++;
         $display("FAIL tx_start_timeout: tx never fell within %0d cycles", w);
      end
   endtask

   // Samples each bit of a frame at its middle; bits[0] is the start bit
   task automatic capture(input int nbits, output logic [15:0] bits);
      int w;
      bits = '0;
      wait_tx_low(w);
      repeat (8) @(negedge clk);
      bits[0] = tx;
      for (int i = 1; i < nbits; i++) begin
         repeat (16) @(negedge clk);
         bits[i] = tx;
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input logic has_par, input logic par,
                          input logic stopb);
      @(negedge clk); rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin rx = d[i]; repeat (16) @(negedge clk); end
      if (has_par) begin rx = par; repeat (16) @(negedge clk); end
      rx = stopb; repeat (16) @(negedge clk);
      rx = 1'b1; repeat (16) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[12];
      logic [7:0]  v;
      logic [15:0] bits;
      logic [15:0] exp_fr;
      logic [7:0]  burst[6];
      logic [7:0]  sent[5];
      int          w;
      logic        tx_hi;

      tbl[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, "rst_con"};
      tbl[1]  = '{1'b0, 2'd2, 8'h00, 8'h50, "rst_stat"};
      tbl[2]  = '{1'b0, 2'd3, 8'h00, 8'h10, "rst_div"};
      tbl[3]  = '{1'b0, 2'd1, 8'h00, 8'h00, "rst_data"};
      tbl[4]  = '{1'b1, 2'd3, 8'h2A, 8'h00, "wr_div"};
      tbl[5]  = '{1'b0, 2'd3, 8'h00, 8'h2A, "div_rw"};
      tbl[6]  = '{1'b1, 2'd0, 8'h1C, 8'h00, "wr_con"};
      tbl[7]  = '{1'b0, 2'd0, 8'h00, 8'h1C, "con_rw"};
      tbl[8]  = '{1'b1, 2'd0, 8'h00, 8'h00, "wr_con0"};
      tbl[9]  = '{1'b1, 2'd3, 8'h00, 8'h00, "wr_div0"};
      tbl[10] = '{1'b0, 2'd3, 8'h00, 8'h00, "div_zero"};
      tbl[11] = '{1'b0, 2'd1, 8'h00, 8'h00, "empty_data"};

      // ---- reset and register access ----
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_irq", irq, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
         else begin rd(tbl[i].a, v); chk(tbl[i].name, v, tbl[i].exp); end
         if (i == 3) begin chk("idle_tx", tx, 1'b1); chk("idle_irq", irq, 1'b0); end
      end
      repeat (100) @(negedge clk);

      // ---- loopback 0xA5, 8N1, exact 16-clk bit timing ----
      wr(2'd0, 8'hC1);
      wr(2'd1, 8'hA5);
      exp_fr = 16'h034A;
      wait_tx_low(w);
      repeat (15) @(negedge clk);
      chk("start_len15", tx, 1'b0);
      @(negedge clk);
      chk("start_len16", tx, 1'b1);
      repeat (8) @(negedge clk);
      for (int i = 1; i < 10; i++) begin
         chk($sformatf("a5_bit%0d", i), tx, exp_fr[i]);
         if (i < 9) repeat (16) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      rd(2'd2, v);
      chk("a5_rx_not_empty", v[4], 1'b0);
      rd_chk("a5_rx_data", 2'd1, 8'hA5);
      rd_chk("a5_stat_after", 2'd2, 8'h50);

      // ---- odd parity loopback, then external bad parity ----
      wr(2'd0, 8'hF1);
      wr(2'd1, 8'h03);
      capture(11, bits);
      chk("par_bit", bits[9], 1'b1);
      chk("par_frame", bits[10:0], 16'h0606);
      repeat (20) @(negedge clk);
      rd_chk("par_rx_data", 2'd1, 8'h03);
      rd_chk("par_no_err", 2'd2, 8'h50);
      wr(2'd0, 8'h70);
      send_rx(8'h55, 1'b1, 1'b0, 1'b1);
      rd_chk("par_err_set", 2'd2, 8'h44);
      wr(2'd2, 8'h04);
      rd_chk("par_err_w1c", 2'd2, 8'h40);
      rd_chk("par_err_data", 2'd1, 8'h55);

      // ---- RX overrun with 5 loopback frames ----
      wr(2'd0, 8'hC1);
      for (int i = 0; i < 5; i++) begin
         wr(2'd1, 8'(8'h11 * (i + 1)));
         repeat (200) @(negedge clk);
      end
      rd_chk("ovr_stat", 2'd2, 8'h68);
      wr(2'd0, 8'h04);
      repeat (2) @(negedge clk);
      chk("irq_rx", irq, 1'b1);
      rd_chk("ovr_rd1", 2'd1, 8'h11);
      rd_chk("ovr_rd2", 2'd1, 8'h22);
      rd_chk("ovr_rd3", 2'd1, 8'h33);
      rd_chk("ovr_rd4", 2'd1, 8'h44);
      rd_chk("ovr_rd5", 2'd1, 8'h00);
      repeat (2) @(negedge clk);
      chk("irq_rx_clear", irq, 1'b0);
      wr(2'd2, 8'h08);
      rd_chk("ovr_w1c", 2'd2, 8'h50);
      wr(2'd0, 8'h02);
      repeat (2) @(negedge clk);
      chk("irq_tx", irq, 1'b1);

      // ---- TX FIFO full: drops, then push during pop ----
      wr(2'd0, 8'h00);
      burst = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      @(negedge clk); addr = 2'd1; wen = 1'b1;
      for (int i = 0; i < 6; i++) begin wdata = burst[i]; @(negedge clk); end
      wen = 1'b0;
      rd_chk("txf_full", 2'd2, 8'h90);
      @(negedge clk); addr = 2'd0; wdata = 8'h80; wen = 1'b1;
      @(negedge clk); addr = 2'd1; wdata = 8'h77;
      @(negedge clk); wen = 1'b0;
      sent = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h77};
      for (int i = 0; i < 5; i++) begin
         capture(10, bits);
         chk($sformatf("txf_frame%0d", i), bits[8:1], sent[i]);
      end
      repeat (30) @(negedge clk);
      rd_chk("txf_drained", 2'd2, 8'h50);

      // ---- false start, frame error ----
      wr(2'd0, 8'h40);
      @(negedge clk); rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      rd_chk("false_start", 2'd2, 8'h50);
      send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
      rd_chk("ferr_set", 2'd2, 8'h42);
      rd_chk("ferr_data", 2'd1, 8'h5A);
      wr(2'd2, 8'h02);
      rd_chk("ferr_w1c", 2'd2, 8'h50);

      // ---- reset in the middle of a frame ----
      wr(2'd0, 8'h80);
      wr(2'd1, 8'h3C);
      wr(2'd1, 8'h3D);
      wait_tx_low(w);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_tx", tx, 1'b1);
      tx_hi = 1'b1;
      for (int i = 0; i < 40; i++) begin @(negedge clk); tx_hi &= tx; end
      chk("midrst_tx_stays", tx_hi, 1'b1);
      rd_chk("midrst_stat", 2'd2, 8'h50);
      rd_chk("midrst_con", 2'd0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
